// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: zero-latency forwarding/stall/flush, registered memory-wait FSM with timeout watchdog.
// Freezes all stages on memory wait or watchdog error; HAZARD_PERF_EN builds the stall/flush performance counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        LWE,
  input  logic        tontbE,
  input  logic        mem_accessM,
  input  logic        mem_ready,
  output logic        stalF,
  output logic        stalD,
  output logic        stalE,
  output logic        stalM,
  output logic        stalW,
  output logic        flushD,
  output logic        flushE,
  output logic [1:0]  forwardAE,
  output logic [1:0]  forwardBE,
  output logic        mem_wait,
  output logic        timeout_err,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, cnt_nxt;
  logic             err_nxt;
  logic             lwstall, memstall, freeze;

  assign lwstall  = LWE && ((RtE == RsD) || (RtE == RtD));
  assign memstall = mem_accessM && !mem_ready;
  assign freeze   = memstall || (state == ERR);
  assign mem_wait = (state == MEM_WAIT);

  // E-stage producer tags are not forwarding sources; a load in E is handled by the interlock.
  logic unused_e;
  assign unused_e = RegWriteE ^ (^WriteRegE);

  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (reset) begin
      if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RsE))      forwardAE = 2'b10;
      else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RsE)) forwardAE = 2'b01;
      if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RtE))      forwardBE = 2'b10;
      else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RtE)) forwardBE = 2'b01;
    end
  end

  always_comb begin
    stalF  = 1'b0;
    stalD  = 1'b0;
    stalE  = 1'b0;
    stalM  = 1'b0;
    stalW  = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    if (reset) begin
      if (freeze) begin
        // Whole pipe holds; a pending branch or load-use re-evaluates once E moves again.
        stalF = 1'b1;
        stalD = 1'b1;
        stalE = 1'b1;
        stalM = 1'b1;
        stalW = 1'b1;
      end else if (tontbE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (lwstall) begin
        stalF  = 1'b1;
        stalD  = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    err_nxt   = timeout_err;
    case (state)
      RUN: begin
        if (memstall) begin
          state_nxt = MEM_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      MEM_WAIT: begin
        if (mem_ready || !mem_accessM) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (wait_cnt == CNT_LAST) begin
          state_nxt = ERR;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = wait_cnt + CNT_ONE;
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= cnt_nxt;
      timeout_err <= err_nxt;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (stalF)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flushE) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl with MEM_TIMEOUT = 4; perf expectations follow HAZARD_PERF_EN.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW, LWE, tontbE, mem_accessM, mem_ready;
  logic        stalF, stalD, stalE, stalM, stalW, flushD, flushE;
  logic [1:0]  forwardAE, forwardBE;
  logic        mem_wait, timeout_err;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LWE(LWE), .tontbE(tontbE), .mem_accessM(mem_accessM), .mem_ready(mem_ready),
    .stalF(stalF), .stalD(stalD), .stalE(stalE), .stalM(stalM), .stalW(stalW),
    .flushD(flushD), .flushE(flushE), .forwardAE(forwardAE), .forwardBE(forwardBE),
    .mem_wait(mem_wait), .timeout_err(timeout_err),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  typedef struct {
    string      tag;
    logic [4:0] stal;   // {F,D,E,M,W}
    logic [1:0] flush;  // {D,E}
    logic [1:0] fa;
    logic [1:0] fb;
    logic       mw;
    logic       te;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  int unsigned exp_ps = 0;
  int unsigned exp_pf = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    LWE = 0; tontbE = 0; mem_accessM = 0; mem_ready = 0;
  endtask

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    if (!reset) begin
      exp_ps = 0;
      exp_pf = 0;
    end
    chk({e.tag, "/stal"}, 32'({stalF, stalD, stalE, stalM, stalW}), 32'(e.stal));
    chk({e.tag, "/flush"}, 32'({flushD, flushE}), 32'(e.flush));
    chk({e.tag, "/fwdA"}, 32'(forwardAE), 32'(e.fa));
    chk({e.tag, "/fwdB"}, 32'(forwardBE), 32'(e.fb));
    chk({e.tag, "/mem_wait"}, 32'(mem_wait), 32'(e.mw));
    chk({e.tag, "/timeout_err"}, 32'(timeout_err), 32'(e.te));
    chk({e.tag, "/perf_stall"}, perf_stall_cnt, PERF ? exp_ps : 32'd0);
    chk({e.tag, "/perf_flush"}, perf_flush_cnt, PERF ? exp_pf : 32'd0);
    if (e.stal[4])  exp_ps++;
    if (e.flush[0]) exp_pf++;
  endtask

  // Called right after inputs are driven at a falling edge; returns at the next falling edge.
  task automatic cyc(input string tag, input logic [4:0] stal, input logic [1:0] flush,
                     input logic [1:0] fa, input logic [1:0] fb, input logic mw, input logic te);
    exp_t e;
    e.tag = tag; e.stal = stal; e.flush = flush; e.fa = fa; e.fb = fb; e.mw = mw; e.te = te;
    sb.push_back(e);
    #1;
    check_out();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    clear_in();
    RegWriteM = 1; WriteRegM = 5; RsE = 5; LWE = 1; RtE = 3; RsD = 3;
    tontbE = 1; mem_accessM = 1;
    @(negedge clk);
    cyc("rst_a", 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc("rst_b", 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0);
    clear_in();
    reset = 1'b1;
    cyc("idle", 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0);

    RegWriteM = 1; WriteRegM = 5; RsE = 5; RegWriteW = 1; WriteRegW = 5;
    cyc("fwdA_m", 5'b00000, 2'b00, 2'b10, 2'b00, 0, 0);
    RegWriteM = 0;
    cyc("fwdA_w", 5'b00000, 2'b00, 2'b01, 2'b00, 0, 0);
    RegWriteM = 1; WriteRegM = 0; WriteRegW = 0; RsE = 0;
    cyc("fwdA_r0", 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0);
    WriteRegM = 7; WriteRegW = 7; RtE = 7;
    cyc("fwdB_m", 5'b00000, 2'b00, 2'b00, 2'b10, 0, 0);
    RegWriteM = 0;
    cyc("fwdB_w", 5'b00000, 2'b00, 2'b00, 2'b01, 0, 0);
    clear_in();

    LWE = 1; RtE = 8; RsD = 8;
    cyc("lu_rs", 5'b11000, 2'b01, 2'b00, 2'b00, 0, 0);
    LWE = 0;
    cyc("lu_rs_after", 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0);
    LWE = 1; RsD = 0; RtD = 8;
    cyc("lu_rt", 5'b11000, 2'b01, 2'b00, 2'b00, 0, 0);
    LWE = 0;
    cyc("lu_rt_after", 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0);
    LWE = 1; RsD = 9; RtD = 9;
    cyc("lu_none", 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0);
    LWE = 1; RsD = 8; tontbE = 1;
    cyc("br_over_lu", 5'b00000, 2'b11, 2'b00, 2'b00, 0, 0);
    clear_in();
    cyc("perf_mid", 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0);

    mem_accessM = 1; tontbE = 1;
    cyc("mw_1", 5'b11111, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc("mw_2", 5'b11111, 2'b00, 2'b00, 2'b00, 1, 0);
    cyc("mw_3", 5'b11111, 2'b00, 2'b00, 2'b00, 1, 0);
    mem_ready = 1;
    cyc("mw_ready", 5'b00000, 2'b11, 2'b00, 2'b00, 1, 0);
    clear_in();
    cyc("mw_done", 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0);

    mem_accessM = 1;
    cyc("abort_1", 5'b11111, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc("abort_2", 5'b11111, 2'b00, 2'b00, 2'b00, 1, 0);
    mem_accessM = 0;
    cyc("abort_drop", 5'b00000, 2'b00, 2'b00, 2'b00, 1, 0);
    cyc("abort_run", 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0);

    mem_accessM = 1;
    cyc("wd_1", 5'b11111, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc("wd_2", 5'b11111, 2'b00, 2'b00, 2'b00, 1, 0);
    cyc("wd_3", 5'b11111, 2'b00, 2'b00, 2'b00, 1, 0);
    cyc("wd_4", 5'b11111, 2'b00, 2'b00, 2'b00, 1, 0);
    cyc("wd_err", 5'b11111, 2'b00, 2'b00, 2'b00, 0, 1);
    mem_ready = 1; tontbE = 1;
    cyc("wd_err_rdy", 5'b11111, 2'b00, 2'b00, 2'b00, 0, 1);
    reset = 1'b0;
    cyc("wd_reset", 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0);
    clear_in();
    reset = 1'b1;
    cyc("wd_cleared", 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0);
    LWE = 1; RtE = 4; RtD = 4;
    cyc("post_lu", 5'b11000, 2'b01, 2'b00, 2'b00, 0, 0);
    clear_in();
    cyc("post_idle", 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0);

    mem_accessM = 1;
    cyc("rw_1", 5'b11111, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc("rw_2", 5'b11111, 2'b00, 2'b00, 2'b00, 1, 0);
    reset = 1'b0;
    cyc("rw_reset", 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0);
    clear_in();
    reset = 1'b1;
    cyc("rw_run", 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage MIPS-style pipeline.
- Generates all per-stage stall, flush and forwarding selects: EX forwarding, load-use interlock, taken-branch flush and data-memory wait freeze.
- Runs a memory-wait FSM with a timeout watchdog that latches a sticky error and freezes the pipeline.
- Sits beside the datapath; consumes its register tags and control bits, drives its stall/flush/forward inputs.

Parameters:
- MEM_TIMEOUT, 64: consecutive MEM_WAIT cycles that trip the watchdog; legal range 2 to 2^CNT_W-1.
- CNT_W, 8: width of the wait counter.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- RsD, RtD  in  5 each  decode-stage source register tags
- RsE, RtE  in  5 each  execute-stage source register tags
- WriteRegE, WriteRegM, WriteRegW  in  5 each  destination tags in E/M/W
- RegWriteE, RegWriteM, RegWriteW  in  1 each  register-write enables in E/M/W
- LWE  in  1  load word in E
- tontbE  in  1  branch taken, resolved in E
- mem_accessM  in  1  load or store in M
- mem_ready  in  1  data memory completes this cycle
- stalF, stalD, stalE, stalM, stalW  out  1 each  hold stage register
- flushD, flushE  out  1 each  clear stage register to bubble
- forwardAE, forwardBE  out  2 each  00 = register file, 01 = ResultW, 10 = ALUOutM
- mem_wait  out  1  FSM in MEM_WAIT
- timeout_err  out  1  sticky watchdog error
- perf_stall_cnt, perf_flush_cnt  out  32 each  performance counters

Behaviour:
- Reset (reset = 0):
  - state = RUN, wait_cnt = 0, timeout_err = 0, perf counters = 0.
  - All stall/flush outputs = 0, forwardAE = forwardBE = 00, regardless of inputs.
- Forwarding (combinational, zero latency):
  - forwardAE = 10 if RegWriteM && WriteRegM != 0 && WriteRegM == RsE.
  - Else forwardAE = 01 if RegWriteW && WriteRegW != 0 && WriteRegW == RsE.
  - Else forwardAE = 00.
  - forwardBE uses the same rule on RtE.
  - M has priority over W. Register 0 is never forwarded.
- Condition terms (combinational):
  - lwstall = LWE && (RtE == RsD || RtE == RtD).
  - memstall = mem_accessM && !mem_ready.
  - freeze = memstall || state == ERR.
- Priority, highest first:
  1. freeze: stalF = stalD = stalE = stalM = stalW = 1; flushD = flushE = 0. A pending tontbE or lwstall is deferred; E is held, so it re-evaluates on unfreeze.
  2. tontbE: flushD = flushE = 1; no stalls, so the PC loads the branch target. Any coincident lwstall is discarded, since the consumer is flushed.
  3. lwstall: stalF = stalD = 1, flushE = 1, for exactly one cycle. The next cycle LWE = 0 because a bubble is in E.
  4. Otherwise all stall/flush outputs = 0.
- FSM (registered, states RUN / MEM_WAIT / ERR):
  - RUN -> MEM_WAIT when memstall; wait_cnt <= 1.
  - MEM_WAIT -> RUN when mem_ready; wait_cnt <= 0. The stall releases combinationally in that same cycle.
  - MEM_WAIT stays while !mem_ready; wait_cnt increments.
  - MEM_WAIT -> ERR when !mem_ready && wait_cnt == MEM_TIMEOUT-1; timeout_err <= 1.
  - ERR is terminal until reset; all stages held.
  - mem_wait = (state == MEM_WAIT).
  - mem_accessM deasserting while in MEM_WAIT: return to RUN; wait_cnt <= 0.
- Reset asserted mid-wait: immediate return to RUN, counters cleared; no error.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - perf_stall_cnt increments each cycle stalF = 1.
  - perf_flush_cnt increments each cycle flushE = 1.
  - Both are 32-bit, wrap at 2^32-1 -> 0, and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Forwarding: RegWriteM = 1, WriteRegM = 5, RsE = 5, and RegWriteW = 1, WriteRegW = 5 -> forwardAE = 10. Drop RegWriteM -> forwardAE = 01. Set WriteRegM = WriteRegW = RsE = 0 -> forwardAE = 00.
- Load-use: LWE = 1, RtE = 8, RsD = 8 -> one cycle of stalF = stalD = flushE = 1; next cycle (LWE = 0) all 0. RtE = 8, RsD = RtD = 9 -> no stall.
- Branch vs load-use: tontbE = 1 and lwstall = 1 together -> flushD = flushE = 1, stalF = 0.
- Memory wait: mem_accessM = 1, mem_ready = 0 for 3 cycles, then 1 -> all five stalls = 1 for 3 cycles; mem_wait = 1 from the 2nd through 4th cycle; stalls = 0 in the ready cycle. tontbE held through the wait -> flush only after release.
- Watchdog: MEM_TIMEOUT = 4, mem_ready held 0 -> state ERR and timeout_err = 1 after the 4th wait cycle; stalls stay 1 even after mem_ready = 1, until reset = 0.
- HAZARD_PERF_EN: 2 load-use stalls + 1 branch flush -> perf_stall_cnt = 2, perf_flush_cnt = 3. Reset = 0 mid-run -> both 0. Without macro -> both always 0.
